// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO in arbitrated bursts.
// Define FLUSH_TIMEOUT_EN to flush partial bursts after an idle timeout.
module fifo_burst_reader #(
   parameter int DATA_DEPTH = 256,
   parameter int W_DATA     = 64,
   parameter int W_COUNT    = 8,
   parameter int BURST_LEN  = 16,
   parameter int W_BURST    = 5,
   parameter int TIMEOUT    = 255,
   parameter int W_TIMER    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [W_DATA-1:0]  fifo_rd_data,
   input  logic [W_COUNT-1:0] fifo_words_used,
   input  logic               fifo_is_empty,
   input  logic               fifo_is_full,
   output logic               fifo_rd_en,
   output logic               req,
   input  logic               gnt,
   output logic [W_BURST-1:0] out_len,
   output logic [W_DATA-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sop,
   output logic               out_eop
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XFER
   } state_t;

   localparam logic [W_COUNT:0] DEPTH_C =
      (W_COUNT+1)'(DATA_DEPTH);
   localparam logic [W_COUNT:0] BURST_C =
      (W_COUNT+1)'(BURST_LEN);
   localparam logic [W_BURST-1:0] BURST_B =
      W_BURST'(BURST_LEN);
   localparam logic [W_BURST-1:0] ONE_B =
      W_BURST'(1);

   state_t               state;
   state_t               state_nxt;
   logic [W_BURST-1:0]   beat_cnt;
   logic [W_BURST-1:0]   beat_nxt;
   logic [W_BURST-1:0]   len_nxt;
   logic [W_COUNT:0]     occ;
   logic                 flush;
   logic                 last_beat;

   // usedw wraps to 0 at full, so full overrides it
   assign occ = fifo_is_full ? DEPTH_C
                             : {1'b0, fifo_words_used};

   assign last_beat = (beat_cnt == out_len - ONE_B);

`ifdef FLUSH_TIMEOUT_EN
   localparam logic [W_TIMER-1:0] TIMEOUT_C =
      W_TIMER'(TIMEOUT);

   logic [W_TIMER-1:0] timer;

   // Count quiet idle cycles holding a partial burst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else if (state != S_IDLE ||
                   state_nxt != S_IDLE ||
                   fifo_is_empty) begin
         timer <= '0;
      end else if (occ < BURST_C &&
                   timer != TIMEOUT_C) begin
         timer <= timer + W_TIMER'(1);
      end
   end

   assign flush = (timer == TIMEOUT_C) && !fifo_is_empty;
`else
   // Timer compiled out; sizing parameters stay referenced
   logic unused_cfg;
   assign unused_cfg = ^{32'(TIMEOUT), 32'(W_TIMER)};
   assign flush = 1'b0;
`endif

   // Next state, burst bookkeeping and stream outputs
   always_comb begin
      state_nxt  = state;
      len_nxt    = out_len;
      beat_nxt   = beat_cnt;
      out_valid  = 1'b0;
      out_sop    = 1'b0;
      out_eop    = 1'b0;
      fifo_rd_en = 1'b0;
      out_data   = fifo_rd_data;
      unique case (state)
         S_IDLE: begin
            if (occ >= BURST_C) begin
               len_nxt   = BURST_B;
               state_nxt = S_REQ;
            end else if (flush) begin
               len_nxt   = W_BURST'(occ);
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (gnt) begin
               beat_nxt  = '0;
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            out_valid  = !fifo_is_empty;
            out_sop    = out_valid && (beat_cnt == '0);
            out_eop    = out_valid && last_beat;
            fifo_rd_en = out_valid && out_ready;
            if (fifo_rd_en) begin
               if (last_beat) begin
                  state_nxt = S_IDLE;
               end else begin
                  beat_nxt = beat_cnt + ONE_B;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, latched length, beat count and registered req
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         out_len  <= '0;
         beat_cnt <= '0;
         req      <= 1'b0;
      end else begin
         state    <= state_nxt;
         out_len  <= len_nxt;
         beat_cnt <= beat_nxt;
         req      <= (state_nxt == S_REQ);
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: FIFO/arbiter environment plus burst model.
// Expectations adapt when FLUSH_TIMEOUT_EN is defined.
module tb_fifo_burst_reader;

   localparam int DEPTH = 256;
   localparam int WD    = 64;
   localparam int WC    = 8;
   localparam int BL    = 16;
   localparam int WB    = 5;
   localparam int TO    = 10;
   localparam int WT    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [WD-1:0] fifo_rd_data;
   logic [WC-1:0] fifo_words_used;
   logic          fifo_is_empty;
   logic          fifo_is_full;
   logic          fifo_rd_en;
   logic          req;
   logic          gnt;
   logic [WB-1:0] out_len;
   logic [WD-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sop;
   logic          out_eop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .DATA_DEPTH(DEPTH), .W_DATA(WD), .W_COUNT(WC),
      .BURST_LEN(BL), .W_BURST(WB),
      .TIMEOUT(TO), .W_TIMER(WT)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_rd_data(fifo_rd_data),
      .fifo_words_used(fifo_words_used),
      .fifo_is_empty(fifo_is_empty),
      .fifo_is_full(fifo_is_full),
      .fifo_rd_en(fifo_rd_en),
      .req(req), .gnt(gnt),
      .out_len(out_len), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop)
   );

   task automatic chk(string name, logic [63:0] act,
                      logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- FIFO environment ----------------
   logic [WD-1:0] mem [DEPTH];
   logic [7:0]    rd_ptr = 8'd0;
   logic [7:0]    wr_ptr = 8'd0;
   int            count = 0;
   int            pops = 0;
   int            push_n = 0;
   logic [WD-1:0] push_base = '0;

   assign fifo_rd_data    = mem[rd_ptr];
   assign fifo_words_used = 8'(count);
   assign fifo_is_empty   = (count == 0);
   assign fifo_is_full    = (count == DEPTH);

   always @(posedge clk) begin
      int c;
      logic [7:0] w;
      c = count;
      w = wr_ptr;
      if (fifo_rd_en) begin
         chk("pop_nonempty", 64'(c > 0), 64'(1));
         if (c > 0) begin
            rd_ptr <= rd_ptr + 8'd1;
            c--;
            pops <= pops + 1;
         end
      end
      for (int i = 0; i < push_n; i++) begin
         if (c < DEPTH) begin
            mem[w] <= push_base + WD'(i);
            w = w + 8'd1;
            c++;
         end
      end
      wr_ptr <= w;
      count  <= c;
   end

   // ---------------- arbiter and sink ----------------
   int   arb_delay = 3;
   int   arb_cnt = 0;
   logic arb_gnt = 1'b0;
   logic stray_gnt = 1'b0;
   int   rdy_mode = 0;

   assign gnt = arb_gnt | stray_gnt;

   always @(posedge clk) begin
      #1;
      if (req && !arb_gnt) begin
         if (arb_cnt >= arb_delay) begin
            arb_gnt = 1'b1;
            arb_cnt = 0;
         end else begin
            arb_gnt = 1'b0;
            arb_cnt++;
         end
      end else begin
         arb_gnt = 1'b0;
         arb_cnt = 0;
      end
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ~out_ready;
      else out_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- burst model and compare ----------------
   bit            m_req, m_xfer, prev_stall;
   int            m_len, m_beat, m_quiet;
   logic [WD-1:0] prev_data;
   logic          req_d = 1'b0;
   bit            in_burst;
   int            req_rises = 0, bursts_done = 0;
   int            cur_beats = 0, last_beats = 0;
   int            len_at_req = 0, ne_cycles = 0;
   int            ne_at_req = 0, gap = 0, gap_at_req = 0;
   logic [WD-1:0] first_data, last_data;

   always @(negedge clk) begin
      bit ev;
      bit fire;
      if (!rst) begin
         m_req = 0; m_xfer = 0; m_len = 0;
         m_beat = 0; m_quiet = 0; prev_stall = 0;
         in_burst = 0; cur_beats = 0;
         ne_cycles = 0; req_d = 1'b0;
         chk("rst_outs",
             64'({req, out_valid, fifo_rd_en,
                  out_sop, out_eop}), 64'(0));
         chk("rst_len", 64'(out_len), 64'(0));
      end else begin
         ev   = m_xfer && (count > 0);
         fire = ev && out_ready;
         chk("req", 64'(req), 64'(m_req));
         chk("valid", 64'(out_valid), 64'(ev));
         chk("sop", 64'(out_sop), 64'(ev && m_beat == 0));
         chk("eop", 64'(out_eop),
             64'(ev && m_beat == m_len - 1));
         chk("rd_en", 64'(fifo_rd_en), 64'(fire));
         chk("len", 64'(out_len), 64'(m_len));
         if (ev) chk("data", out_data, mem[rd_ptr]);
         if (ev && prev_stall)
            chk("hold", out_data, prev_data);

         gap++;
         if (count == 0) ne_cycles = 0;
         else if (!req && !in_burst) ne_cycles++;
         if (req && !req_d) begin
            req_rises++;
            len_at_req = int'(out_len);
            ne_at_req  = ne_cycles;
            gap_at_req = gap;
            ne_cycles  = 0;
            in_burst   = 1;
         end
         req_d = req;
         if (out_valid && out_ready) begin
            if (out_sop) first_data = out_data;
            cur_beats++;
            if (out_eop) begin
               last_beats = cur_beats;
               last_data  = out_data;
               cur_beats  = 0;
               in_burst   = 0;
               gap        = 0;
               bursts_done++;
            end
         end

         if (m_xfer) begin
            if (fire) begin
               if (m_beat == m_len - 1) m_xfer = 0;
               else m_beat++;
            end
         end else if (m_req) begin
            if (gnt) begin
               m_req = 0; m_xfer = 1; m_beat = 0;
            end
         end else if (count >= BL) begin
            m_len = BL; m_req = 1; m_quiet = 0;
`ifdef FLUSH_TIMEOUT_EN
         end else if (m_quiet == TO && count > 0) begin
            m_len = count; m_req = 1; m_quiet = 0;
         end else if (count == 0) begin
            m_quiet = 0;
         end else if (m_quiet < TO) begin
            m_quiet++;
`endif
         end
         prev_stall = ev && !out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(int n, logic [WD-1:0] base);
      push_n = n;
      push_base = base;
      cyc(1);
      push_n = 0;
   endtask

   task automatic wait_bursts(int target, int budget);
      int n = 0;
      while (bursts_done < target && n < budget) begin
         cyc(1);
         n++;
      end
      chk("burst_done", 64'(bursts_done >= target), 64'(1));
      cyc(2);
   endtask

   initial begin
      int b0, p0, r0, n;
      logic [WD-1:0] exp_head;

      cyc(3);
      chk("init_req", 64'(req), 64'(0));
      chk("init_len", 64'(out_len), 64'(0));
      rst = 1'b1;
      cyc(3);

      // full burst, gnt 3 cycles after req
      b0 = bursts_done; p0 = pops;
      push(16, 64'h0);
      wait_bursts(b0 + 1, 200);
      chk("t1_beats", 64'(last_beats), 64'(16));
      chk("t1_first", first_data, 64'h0);
      chk("t1_last", last_data, 64'hF);
      chk("t1_len", 64'(len_at_req), 64'(16));
      chk("t1_pops", 64'(pops - p0), 64'(16));

      // backpressure 1010...
      rdy_mode = 1;
      b0 = bursts_done; p0 = pops;
      push(16, 64'h20);
      wait_bursts(b0 + 1, 200);
      chk("t2_beats", 64'(last_beats), 64'(16));
      chk("t2_last", last_data, 64'h2F);
      chk("t2_pops", 64'(pops - p0), 64'(16));

      // full FIFO: usedw reads 0
      rdy_mode = 2; arb_delay = 1;
      b0 = bursts_done; p0 = pops; r0 = req_rises;
      push(256, 64'h1000);
      n = 0;
      while (!req && n < 20) begin cyc(1); n++; end
      chk("t3_req", 64'(req), 64'(1));
      chk("t3_len", 64'(out_len), 64'(16));
      wait_bursts(b0 + 16, 3000);
      cyc(100);
      chk("t3_reqs", 64'(req_rises - r0), 64'(16));
      chk("t3_pops", 64'(pops - p0), 64'(256));
      chk("t3_last", last_data, 64'h10FF);

      // partial burst, timeout flush
      rdy_mode = 0; arb_delay = 3;
      b0 = bursts_done; r0 = req_rises;
      push(3, 64'h2000);
`ifdef FLUSH_TIMEOUT_EN
      wait_bursts(b0 + 1, 200);
      chk("t4_quiet", 64'(ne_at_req), 64'(11));
      chk("t4_len", 64'(len_at_req), 64'(3));
      chk("t4_beats", 64'(last_beats), 64'(3));
      chk("t4_first", first_data, 64'h2000);
      chk("t4_last", last_data, 64'h2002);
`else
      cyc(300);
      chk("t4_noreq", 64'(req_rises - r0), 64'(0));
`endif

      // stray grants in IDLE and XFER
      b0 = bursts_done; r0 = req_rises;
      stray_gnt = 1'b1;
      cyc(1);
      stray_gnt = 1'b0;
      cyc(3);
      chk("t5_idle_gnt", 64'(req_rises - r0), 64'(0));
      push(20, 64'h3000);
      n = 0;
      while (!out_valid && n < 50) begin cyc(1); n++; end
      chk("t5_xfer", 64'(out_valid), 64'(1));
      cyc(1);
      stray_gnt = 1'b1;
      cyc(1);
      stray_gnt = 1'b0;
      wait_bursts(b0 + 1, 200);
      chk("t5_beats", 64'(last_beats), 64'(16));
`ifdef FLUSH_TIMEOUT_EN
      chk("t5_first", first_data, 64'h3000);
      chk("t5_last", last_data, 64'h300F);
      wait_bursts(b0 + 2, 200);
      chk("t5_len2", 64'(len_at_req), 64'(4));
      chk("t5_quiet", 64'(ne_at_req), 64'(11));
      chk("t5_gap", 64'(gap_at_req >= 2), 64'(1));
`else
      chk("t5_first", first_data, 64'h2000);
      chk("t5_last", last_data, 64'h300C);
      cyc(300);
      chk("t5_noreq", 64'(req_rises - r0), 64'(1));
`endif

      // reset at beat 5 of 16
      push(16, 64'h4000);
      n = 0;
      while (cur_beats < 5 && n < 100) begin cyc(1); n++; end
      chk("t6_beat5", 64'(cur_beats), 64'(5));
      chk("t6_pre_valid", 64'(out_valid), 64'(1));
      b0 = bursts_done;
      #1 rst = 1'b0;
      #1;
      chk("t6_async",
          64'({req, out_valid, fifo_rd_en, out_sop, out_eop}),
          64'(0));
      cyc(2);
      exp_head = mem[rd_ptr];
      rst = 1'b1;
      chk("t6_idle", 64'(req), 64'(0));
      wait_bursts(b0 + 1, 200);
      chk("t6_first", first_data, exp_head);
`ifdef FLUSH_TIMEOUT_EN
      chk("t6_beats", 64'(last_beats), 64'(11));
`else
      chk("t6_beats", 64'(last_beats), 64'(16));
`endif

      // randomized traffic
      rdy_mode = 2;
      for (int i = 0; i < 800; i++) begin
         if (i % 50 == 0) arb_delay = $urandom_range(0, 4);
         if ($urandom_range(0, 3) == 0 && count < 200)
            push($urandom_range(1, 8), {$urandom, $urandom});
         else
            cyc(1);
      end
      cyc(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
